// File: rtl/tetris_pkg.sv
// Shared board geometry, block encodings and plotter state encoding.
package tetris_pkg;

  localparam int BOARD_W  = 10;
  localparam int BOARD_H  = 20;
  localparam int COLOUR_W = 6;
  localparam int OFS_W    = 2;

  typedef enum logic [2:0] {
    BLK_I = 3'd0,
    BLK_J = 3'd1,
    BLK_L = 3'd2,
    BLK_O = 3'd3,
    BLK_S = 3'd4,
    BLK_T = 3'd5,
    BLK_Z = 3'd6
  } block_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_DRAW = 2'd1,
    ST_DONE = 2'd2
  } plot_state_t;

  // Pull the 2-bit offset of cell idx out of a packed four-cell offset word.
  function automatic logic [OFS_W-1:0] cell_ofs(input logic [4*OFS_W-1:0] packed_ofs,
                                                input logic [1:0]         idx);
    return packed_ofs[idx*OFS_W +: OFS_W];
  endfunction

endpackage

// File: rtl/piece_pixel_addr.sv
// Combinational pixel address for one pixel of one tetromino cell, plus an
// off-board flag for cells that land outside the 10x20 playfield.
module piece_pixel_addr
  import tetris_pkg::*;
#(
  parameter int unsigned CELL_PX  = 4,
  parameter int unsigned BOARD_X0 = 0,
  parameter int unsigned BOARD_Y0 = 0
) (
  input  logic [3:0] org_x,
  input  logic [4:0] org_y,
  input  logic [7:0] cell_x,
  input  logic [7:0] cell_y,
  input  logic [1:0] idx,
  input  logic [2:0] px,
  input  logic [2:0] py,
  output logic [7:0] vga_x,
  output logic [6:0] vga_y,
  output logic       out_of_board
);

  logic [4:0] cc;
  logic [4:0] cr;

  // Board cell coordinates, then pixel coordinates; modular arithmetic at the
  // output widths equals computing wider and truncating.
  always_comb begin
    cc           = 5'(org_x) + 5'(cell_ofs(cell_x, idx));
    cr           = org_y + 5'(cell_ofs(cell_y, idx));
    out_of_board = (cc > 5'(BOARD_W - 1)) || (cr > 5'(BOARD_H - 1));
    vga_x        = 8'(BOARD_X0) + 8'(cc) * 8'(CELL_PX) + 8'(px);
    vga_y        = 7'(BOARD_Y0) + 7'(cr) * 7'(CELL_PX) + 7'(py);
  end

endmodule

// File: rtl/piece_plotter.sv
// Serially plots (or erases) a tetromino onto the VGA pixel plane, one pixel
// per plot/plot_ready handshake.
//
// state   | meaning
// --------+--------------------------------------------------------------
// ST_IDLE | waiting for start; inputs latched on start
// ST_DRAW | walking cells 0..3, row-major pixels; off-board cells skip 1 cycle
// ST_DONE | one-cycle done pulse, then back to idle
module piece_plotter
  import tetris_pkg::*;
#(
  parameter int unsigned CELL_PX   = 4,
  parameter int unsigned BOARD_X0  = 0,
  parameter int unsigned BOARD_Y0  = 0,
  parameter logic [5:0]  BG_COLOUR = 6'b000000
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic       start,
  input  logic       erase,
  input  logic [3:0] board_x,
  input  logic [4:0] board_y,
  input  logic [7:0] cell_x,
  input  logic [7:0] cell_y,
  input  logic [5:0] colour,
  input  logic       plot_ready,
  output logic [7:0] vga_x,
  output logic [6:0] vga_y,
  output logic [5:0] vga_colour,
  output logic       plot,
  output logic       busy,
  output logic       done
);

  localparam logic [2:0] PX_LAST = 3'(CELL_PX - 1);

  plot_state_t state, n_state;
  logic [1:0]  idx, n_idx;
  logic [2:0]  px, n_px;
  logic [2:0]  py, n_py;
  logic [3:0]  org_x, n_org_x;
  logic [4:0]  org_y, n_org_y;
  logic [7:0]  ofs_x, n_ofs_x;
  logic [7:0]  ofs_y, n_ofs_y;
  logic [5:0]  col, n_col;

  logic [7:0]  addr_x;
  logic [6:0]  addr_y;
  logic        addr_oob;

  // The address is computed from the next-cycle counters so that the pixel
  // outputs can be registered and still line up with the counter state.
  piece_pixel_addr #(
    .CELL_PX  (CELL_PX),
    .BOARD_X0 (BOARD_X0),
    .BOARD_Y0 (BOARD_Y0)
  ) u_addr (
    .org_x        (n_org_x),
    .org_y        (n_org_y),
    .cell_x       (n_ofs_x),
    .cell_y       (n_ofs_y),
    .idx          (n_idx),
    .px           (n_px),
    .py           (n_py),
    .vga_x        (addr_x),
    .vga_y        (addr_y),
    .out_of_board (addr_oob)
  );

  // Next-state, counter advance and input latching.
  always_comb begin
    n_state = state;
    n_idx   = idx;
    n_px    = px;
    n_py    = py;
    n_org_x = org_x;
    n_org_y = org_y;
    n_ofs_x = ofs_x;
    n_ofs_y = ofs_y;
    n_col   = col;
    case (state)
      ST_IDLE: begin
        if (start) begin
          n_org_x = board_x;
          n_org_y = board_y;
          n_ofs_x = cell_x;
          n_ofs_y = cell_y;
          n_col   = erase ? BG_COLOUR : colour;
          n_idx   = 2'd0;
          n_px    = 3'd0;
          n_py    = 3'd0;
          n_state = ST_DRAW;
        end
      end
      ST_DRAW: begin
        // plot=0 in DRAW marks a skip cycle for an off-board cell.
        if (!plot || plot_ready) begin
          if (!plot || (px == PX_LAST && py == PX_LAST)) begin
            n_px = 3'd0;
            n_py = 3'd0;
            if (idx == 2'd3) n_state = ST_DONE;
            else             n_idx   = idx + 2'd1;
          end else if (px == PX_LAST) begin
            n_px = 3'd0;
            n_py = py + 3'd1;
          end else begin
            n_px = px + 3'd1;
          end
        end
      end
      ST_DONE: n_state = ST_IDLE;
      default: n_state = ST_IDLE;
    endcase
  end

  // State, counters and latched piece description.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state <= ST_IDLE;
      idx   <= 2'd0;
      px    <= 3'd0;
      py    <= 3'd0;
      org_x <= 4'd0;
      org_y <= 5'd0;
      ofs_x <= 8'd0;
      ofs_y <= 8'd0;
      col   <= 6'd0;
    end else begin
      state <= n_state;
      idx   <= n_idx;
      px    <= n_px;
      py    <= n_py;
      org_x <= n_org_x;
      org_y <= n_org_y;
      ofs_x <= n_ofs_x;
      ofs_y <= n_ofs_y;
      col   <= n_col;
    end
  end

  // Registered write port; pixel fields hold while a write is stalled.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      vga_x      <= 8'd0;
      vga_y      <= 7'd0;
      vga_colour <= 6'd0;
      plot       <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else begin
      busy <= (n_state != ST_IDLE);
      done <= (n_state == ST_DONE);
      if (n_state == ST_DRAW && !addr_oob) begin
        plot       <= 1'b1;
        vga_x      <= addr_x;
        vga_y      <= addr_y;
        vga_colour <= n_col;
      end else begin
        plot <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_piece_plotter.sv
// Directed self-checking bench for piece_plotter (CELL_PX=4, origin 0,0).
module tb_piece_plotter;

  logic       clk = 1'b0;
  logic       resetn;
  logic       start;
  logic       erase;
  logic [3:0] board_x;
  logic [4:0] board_y;
  logic [7:0] cell_x;
  logic [7:0] cell_y;
  logic [5:0] colour;
  logic       plot_ready;
  logic [7:0] vga_x;
  logic [6:0] vga_y;
  logic [5:0] vga_colour;
  logic       plot;
  logic       busy;
  logic       done;

  int checks   = 0;
  int failures = 0;

  int exp_x[$];
  int exp_y[$];
  bit exp_p[$];

  localparam logic [7:0] I_CX = 8'b00_01_10_11;
  localparam logic [7:0] O_CX = 8'b01_00_01_00;
  localparam logic [7:0] O_CY = 8'b01_01_00_00;

  piece_plotter #(
    .CELL_PX   (4),
    .BOARD_X0  (0),
    .BOARD_Y0  (0),
    .BG_COLOUR (6'b000000)
  ) dut (
    .clk        (clk),
    .resetn     (resetn),
    .start      (start),
    .erase      (erase),
    .board_x    (board_x),
    .board_y    (board_y),
    .cell_x     (cell_x),
    .cell_y     (cell_y),
    .colour     (colour),
    .plot_ready (plot_ready),
    .vga_x      (vga_x),
    .vga_y      (vga_y),
    .vga_colour (vga_colour),
    .plot       (plot),
    .busy       (busy),
    .done       (done)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog time limit expired");
    $fatal(1);
  end

  task automatic advance();
    @(posedge clk);
    #1;
  endtask

  // Expected plot sequence: one entry per DRAW cycle (skip entries have p=0).
  task automatic build_expected(input int bx, input int by, input logic [7:0] cxp,
                                input logic [7:0] cyp);
    int cc, cr;
    exp_x.delete(); exp_y.delete(); exp_p.delete();
    for (int i = 0; i < 4; i++) begin
      cc = bx + int'((cxp >> (2 * i)) & 8'd3);
      cr = by + int'((cyp >> (2 * i)) & 8'd3);
      if (cc > 9 || cr > 19) begin
        exp_x.push_back(0); exp_y.push_back(0); exp_p.push_back(1'b0);
      end else begin
        for (int yy = 0; yy < 4; yy++)
          for (int xx = 0; xx < 4; xx++) begin
            exp_x.push_back(cc * 4 + xx);
            exp_y.push_back(cr * 4 + yy);
            exp_p.push_back(1'b1);
          end
      end
    end
  endtask

  // Assert start for edge 0; returns at the start of cycle 1 with inputs scrambled.
  task automatic start_draw(input logic [3:0] bx, input logic [4:0] by, input logic [7:0] cx,
                            input logic [7:0] cy, input logic [5:0] col, input logic er);
    board_x = bx; board_y = by; cell_x = cx; cell_y = cy; colour = col; erase = er;
    start = 1'b1;
    advance();
    start = 1'b0;
    board_x = ~bx; board_y = 5'd3; cell_x = ~cx; cell_y = ~cy; colour = ~col; erase = ~er;
  endtask

  task automatic test_reset();
    resetn = 1'b0; start = 1'b0; erase = 1'b0; board_x = '0; board_y = '0;
    cell_x = '0; cell_y = '0; colour = '0; plot_ready = 1'b1;
    #12;
    checks++; if (plot !== 1'b0)       begin failures++; $display("FAIL reset_plot got=%0d exp=0", plot); end
    checks++; if (busy !== 1'b0)       begin failures++; $display("FAIL reset_busy got=%0d exp=0", busy); end
    checks++; if (done !== 1'b0)       begin failures++; $display("FAIL reset_done got=%0d exp=0", done); end
    checks++; if (vga_x !== 8'd0)      begin failures++; $display("FAIL reset_vga_x got=%0d exp=0", vga_x); end
    checks++; if (vga_y !== 7'd0)      begin failures++; $display("FAIL reset_vga_y got=%0d exp=0", vga_y); end
    checks++; if (vga_colour !== 6'd0) begin failures++; $display("FAIL reset_colour got=%b exp=000000", vga_colour); end
    @(negedge clk);
    resetn = 1'b1;
    advance();
    advance();
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL idle_busy got=%0d exp=0", busy); end
  endtask

  task automatic test_draw(input logic er);
    logic [5:0] ecol;
    ecol = er ? 6'b000000 : 6'b001111;
    build_expected(0, 0, I_CX, 8'h00);
    start_draw(4'd0, 5'd0, I_CX, 8'h00, 6'b001111, er);
    checks++; if (vga_x !== 8'd12 || vga_y !== 7'd0)
      begin failures++; $display("FAIL draw_first_pixel erase=%0d got=(%0d,%0d) exp=(12,0)", er, vga_x, vga_y); end
    for (int e = 0; e < 64; e++) begin
      checks++; if (plot !== 1'b1 || busy !== 1'b1 || done !== 1'b0)
        begin failures++; $display("FAIL draw_ctrl erase=%0d cyc=%0d got plot=%0d busy=%0d done=%0d exp 1,1,0", er, e + 1, plot, busy, done); end
      checks++; if (vga_x !== 8'(exp_x[e]) || vga_y !== 7'(exp_y[e]) || vga_colour !== ecol)
        begin failures++; $display("FAIL draw_pixel erase=%0d cyc=%0d got=(%0d,%0d,%b) exp=(%0d,%0d,%b)", er, e + 1, vga_x, vga_y, vga_colour, exp_x[e], exp_y[e], ecol); end
      if (e == 63) begin
        checks++; if (vga_x !== 8'd3 || vga_y !== 7'd3)
          begin failures++; $display("FAIL draw_last_pixel got=(%0d,%0d) exp=(3,3)", vga_x, vga_y); end
      end
      advance();
    end
    checks++; if (done !== 1'b1 || plot !== 1'b0 || busy !== 1'b1)
      begin failures++; $display("FAIL draw_done erase=%0d got done=%0d plot=%0d busy=%0d exp 1,0,1", er, done, plot, busy); end
    advance();
    checks++; if (busy !== 1'b0 || done !== 1'b0)
      begin failures++; $display("FAIL draw_idle erase=%0d got busy=%0d done=%0d exp 0,0", er, busy, done); end
  endtask

  task automatic test_skip();
    build_expected(8, 0, I_CX, 8'h00);
    start_draw(4'd8, 5'd0, I_CX, 8'h00, 6'b110000, 1'b0);
    for (int e = 0; e < 34; e++) begin
      checks++; if (plot !== exp_p[e] || busy !== 1'b1 || done !== 1'b0)
        begin failures++; $display("FAIL skip_ctrl cyc=%0d got plot=%0d busy=%0d done=%0d exp plot=%0d", e + 1, plot, busy, done, exp_p[e]); end
      if (e == 2) begin
        checks++; if (vga_x !== 8'd36 || vga_y !== 7'd0)
          begin failures++; $display("FAIL skip_first_pixel got=(%0d,%0d) exp=(36,0)", vga_x, vga_y); end
      end
      if (exp_p[e]) begin
        checks++; if (vga_x !== 8'(exp_x[e]) || vga_y !== 7'(exp_y[e]) || vga_colour !== 6'b110000)
          begin failures++; $display("FAIL skip_pixel cyc=%0d got=(%0d,%0d,%b) exp=(%0d,%0d,110000)", e + 1, vga_x, vga_y, vga_colour, exp_x[e], exp_y[e]); end
      end
      advance();
    end
    checks++; if (done !== 1'b1 || plot !== 1'b0)
      begin failures++; $display("FAIL skip_done cyc=35 got done=%0d plot=%0d exp 1,0", done, plot); end
    advance();
  endtask

  task automatic test_ready_toggle();
    int acc;
    bit got_done;
    acc = 0;
    got_done = 1'b0;
    build_expected(3, 5, O_CX, O_CY);
    plot_ready = 1'b1;
    start_draw(4'd3, 5'd5, O_CX, O_CY, 6'b101010, 1'b0);
    for (int c = 1; c <= 400 && !got_done; c++) begin
      plot_ready = (((c - 1) % 4) == 0) || (((c - 1) % 4) == 3);
      if (done) begin
        got_done = 1'b1;
      end else begin
        checks++; if (plot !== 1'b1)
          begin failures++; $display("FAIL ready_plot cyc=%0d got=%0d exp=1", c, plot); end
        if (plot && acc >= 64) begin
          checks++; failures++; $display("FAIL ready_extra_pixel cyc=%0d got=(%0d,%0d) exp=none", c, vga_x, vga_y);
        end else if (plot) begin
          checks++; if (vga_x !== 8'(exp_x[acc]) || vga_y !== 7'(exp_y[acc]) || vga_colour !== 6'b101010)
            begin failures++; $display("FAIL ready_pixel cyc=%0d n=%0d got=(%0d,%0d,%b) exp=(%0d,%0d,101010)", c, acc, vga_x, vga_y, vga_colour, exp_x[acc], exp_y[acc]); end
          if (plot_ready) acc++;
        end
        advance();
      end
    end
    plot_ready = 1'b1;
    checks++; if (!got_done) begin failures++; $display("FAIL ready_done_timeout got=0 exp=1"); end
    checks++; if (acc !== 64) begin failures++; $display("FAIL ready_accept_count got=%0d exp=64", acc); end
    advance();
  endtask

  task automatic test_restart_ignored();
    build_expected(0, 0, I_CX, 8'h00);
    start_draw(4'd0, 5'd0, I_CX, 8'h00, 6'b000011, 1'b0);
    for (int e = 0; e < 64; e++) begin
      checks++; if (plot !== 1'b1 || vga_x !== 8'(exp_x[e]) || vga_y !== 7'(exp_y[e]))
        begin failures++; $display("FAIL restart_pixel cyc=%0d got plot=%0d (%0d,%0d) exp=(%0d,%0d)", e + 1, plot, vga_x, vga_y, exp_x[e], exp_y[e]); end
      if (e == 9)  begin start = 1'b1; board_x = 4'd5; cell_x = 8'hFF; end
      if (e == 10) start = 1'b0;
      advance();
    end
    checks++; if (done !== 1'b1) begin failures++; $display("FAIL restart_done got=%0d exp=1", done); end
    start = 1'b1; board_x = 4'd0; cell_x = I_CX;
    advance();
    start = 1'b0;
    checks++; if (busy !== 1'b0 || plot !== 1'b0)
      begin failures++; $display("FAIL restart_start_on_done got busy=%0d plot=%0d exp 0,0", busy, plot); end
    advance();
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL restart_still_idle got busy=%0d exp=0", busy); end
  endtask

  task automatic test_async_reset();
    start_draw(4'd0, 5'd0, I_CX, 8'h00, 6'b111111, 1'b0);
    for (int e = 1; e < 20; e++) advance();
    #2;
    resetn = 1'b0;
    #1;
    checks++; if (plot !== 1'b0 || busy !== 1'b0 || done !== 1'b0)
      begin failures++; $display("FAIL async_reset got plot=%0d busy=%0d done=%0d exp 0,0,0", plot, busy, done); end
    @(negedge clk);
    resetn = 1'b1;
    advance();
    checks++; if (busy !== 1'b0 || plot !== 1'b0)
      begin failures++; $display("FAIL after_reset_idle got busy=%0d plot=%0d exp 0,0", busy, plot); end
    start_draw(4'd2, 5'd1, I_CX, 8'h00, 6'b010101, 1'b0);
    checks++; if (plot !== 1'b1 || vga_x !== 8'd20 || vga_y !== 7'd4 || vga_colour !== 6'b010101)
      begin failures++; $display("FAIL after_reset_first got plot=%0d (%0d,%0d,%b) exp 1 (20,4,010101)", plot, vga_x, vga_y, vga_colour); end
    advance();
    checks++; if (plot !== 1'b1 || vga_x !== 8'd21 || vga_y !== 7'd4)
      begin failures++; $display("FAIL after_reset_second got plot=%0d (%0d,%0d) exp 1 (21,4)", plot, vga_x, vga_y); end
    for (int e = 2; e < 65; e++) advance();
    checks++; if (done !== 1'b1) begin failures++; $display("FAIL after_reset_done got=%0d exp=1", done); end
    advance();
  endtask

  initial begin
    test_reset();
    test_draw(1'b0);
    test_draw(1'b1);
    test_skip();
    test_ready_toggle();
    test_restart_ignored();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/piece_plotter.md
Name: piece_plotter

Overview:
- Consumes the packed tetromino cell offsets and colour produced by the shape lookup: X/Y as four 2-bit fields, colour as 6-bit RRGGBB.
- Serially plots the piece onto the VGA pixel plane, either drawing or erasing it.
- Sits between the game controller, which supplies board position and start, and the VGA adapter write port.
- Each board cell is rendered as a CELL_PX x CELL_PX square of pixels, one pixel write per handshake.

Parameters:
- CELL_PX, 4, pixel edge length of one board cell (power of two, 1..8)
- BOARD_X0, 0, pixel x of board column 0
- BOARD_Y0, 0, pixel y of board row 0
- BG_COLOUR, 6'b000000, colour written in erase mode

Ports:
- clk  in  1  system clock
- resetn  in  1  asynchronous active-low reset
- start  in  1  request to plot; sampled only in IDLE
- erase  in  1  1 = write BG_COLOUR instead of colour; latched with start
- board_x  in  4  piece origin column, 0..9
- board_y  in  5  piece origin row, 0..19
- cell_x  in  8  packed x offsets: [1:0] cell0, [3:2] cell1, [5:4] cell2, [7:6] cell3
- cell_y  in  8  packed y offsets, same packing
- colour  in  6  piece colour RRGGBB
- plot_ready  in  1  VGA side accepts the pixel this cycle
- vga_x  out  8  pixel x
- vga_y  out  7  pixel y
- vga_colour  out  6  pixel colour
- plot  out  1  pixel write valid
- busy  out  1  high whenever state != IDLE
- done  out  1  one-cycle pulse on completion

Behaviour:
- Reset (asynchronous, any state): state=IDLE, all counters 0; vga_x=0, vga_y=0, vga_colour=0, plot=0, busy=0, done=0. A draw in progress is abandoned; no further plots are issued.
- IDLE: on start=1 at an edge, latch board_x, board_y, cell_x, cell_y, erase, and colour (or BG_COLOUR if erase=1). Clear the cell index and px/py counters. Go to DRAW. Inputs may change freely afterwards.
- DRAW:
  - Visit cells in order 0,1,2,3. Within a cell, traverse row-major: py outer, px inner, each 0..CELL_PX-1.
  - Cell column cc = board_x + cx_i; cell row cr = board_y + cy_i, both computed at 5-bit width without truncation.
  - If cc > 9 or cr > 19, the cell is skipped. It consumes exactly one cycle with plot=0, then the next cell is visited.
  - Otherwise the cell is drawn:
    - plot=1, vga_x = BOARD_X0 + cc*CELL_PX + px, vga_y = BOARD_Y0 + cr*CELL_PX + py, vga_colour = latched colour.
    - Outputs are registered and stay stable while plot=1 and plot_ready=0.
    - A pixel is accepted on an edge where plot=1 and plot_ready=1; the next pixel is then presented the following cycle.
    - With plot_ready tied high, one pixel is written per cycle.
  - After the last pixel of cell 3 is accepted (or cell 3 is skipped), go to DONE.
- DONE: done=1 and plot=0 for exactly one cycle, then IDLE. busy=1 through DONE, and busy=0 in the first IDLE cycle.
- Latency: start sampled at edge 0 gives the first plot (or first skip cycle) in cycle 1. With ready high and no skips: plots in cycles 1..4*CELL_PX^2, done in the cycle after the last plot.
- start while busy is ignored, not queued. start in the same cycle as done is also ignored. The controller must re-assert start once busy is low.
- Pixel arithmetic is done at 9 bits and truncated to the output widths. Callers keep BOARD_X0/BOARD_Y0 such that the board fits in 160x120.

Decomposition:
- Package tetris_pkg: BOARD_W=10, BOARD_H=20, COLOUR_W=6, block encodings (I=0, J=1, L=2, O=3, S=4, T=5, Z=6), and the packed-offset field width of 2.
- Sub-module piece_pixel_addr (combinational): takes latched origin, cell offsets, cell index, px, py; produces vga_x, vga_y, and an out_of_board flag.
- The FSM and counters stay in piece_plotter.

Test Plan:
- I piece (cell_x=8'b00_01_10_11, cell_y=0), board (0,0), colour 6'b001111, CELL_PX=4, ready=1, start at edge 0 -> first plot (12,0) colour 001111 in cycle 1; 64 plots; last plot (3,3); done only in cycle 65; busy cycles 1..65.
- Same stimulus with erase=1 -> identical coordinate sequence, every vga_colour=000000.
- I piece at board_x=8 -> cells 0 and 1 skipped (cycles 1,2, plot=0); first plot (36,0) in cycle 3; 32 plots total; done in cycle 35.
- O piece, plot_ready toggling 1,0,0,1,... -> vga_x/vga_y/vga_colour unchanged while plot=1 and ready=0; no pixel duplicated or lost; 64 accepted pixels total.
- start pulsed again mid-draw, with different board_x -> ignored; the coordinate sequence continues from the original latch.
- resetn low in cycle 20 of a draw -> plot=0, busy=0, done=0 immediately, asynchronously. After release, a new start draws from cell 0, px=py=0.
